snoop_ctrl_lv1: RTL
===================

# snoop_ctrl_lv1

L1 snoop-side sequencer for the 4-core MESI cache. Accepts one bus snoop command at a time, arbitrates the shared tag/MESI array port between snoop and processor lookups, and drives the MESI write-back. It also drives the bus `shared` response and the modified-line flush handshake. It consumes the per-way hit vector produced by the snoop hit-detect logic.

## Interface
- ASSOC, 4, number of ways
- ASSOC_WID, 2, log2(ASSOC)
- MESI_WID, 2, MESI state width; encoding I=0, S=1, E=2, M=3
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- bus_rd / bus_rdx / invalidate  in  1 each  snoop command from bus, held until `snoop_done`
- access_blk_snoop  in  ASSOC  one-hot way-hit vector, valid while `snoop_sel`=1
- cache_snoop_mesi  in  ASSOC*MESI_WID  per-way MESI states, way i at [i*MESI_WID +: MESI_WID]
- cpu_lookup_req  in  1  processor side requests the array port; held while in use
- cpu_lookup_gnt  out  1  processor owns the array port
- snoop_sel  out  1  array port muxed to the snoop side
- mesi_wr_en  out  1  one-cycle MESI write strobe
- mesi_wr_blk  out  ASSOC_WID  way index written
- mesi_wr_data  out  MESI_WID  new MESI state
- shared  out  1  bus shared response
- flush_req  out  1  request write-back of modified line
- flush_blk  out  ASSOC_WID  way to flush
- flush_done  in  1  write-back accepted, one-cycle pulse
- snoop_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CPU, LOOKUP, FLUSH, UPDATE, DONE. All outputs registered.
- IDLE:
  - Any snoop command high -> LOOKUP. Latch the command with priority bus_rdx > bus_rd > invalidate.
  - Otherwise, cpu_lookup_req high -> CPU.
  - A snoop beats a simultaneous cpu_lookup_req.
- CPU: cpu_lookup_gnt=1. Stay while cpu_lookup_req=1. When it drops, go to IDLE with gnt=0 next cycle. A pending snoop waits; a processor grant is never preempted.
- LOOKUP (one cycle): snoop_sel=1. Sample access_blk_snoop and the matching way's MESI at end of cycle.
  - No hit -> DONE.
  - Multiple hits (illegal) -> the lowest index wins.
  - Hit way state M with latched bus_rd or bus_rdx -> FLUSH.
  - Any other hit -> UPDATE.
- FLUSH: flush_req=1, flush_blk=hit way, snoop_sel=1. Wait for flush_done, then -> UPDATE.
- UPDATE (one cycle): mesi_wr_en=1, mesi_wr_blk=hit way.
  - mesi_wr_data = S for bus_rd (from M, E or S).
  - mesi_wr_data = I for bus_rdx or invalidate.
  - invalidate never flushes, even when the state is M.
- DONE (one cycle): snoop_done=1, snoop_sel=0 -> IDLE. The requester deasserts its command on the edge where it samples snoop_done=1.
- shared: set when LOOKUP resolves a hit with latched bus_rd. Held through FLUSH/UPDATE/DONE. Cleared entering IDLE.
- snoop_sel=1 in LOOKUP, FLUSH and UPDATE. snoop_sel and cpu_lookup_gnt are never both 1.

## Timing
- Reset (rst=0, asynchronous): state IDLE.
  - All outputs 0: cpu_lookup_gnt, snoop_sel, mesi_wr_en, mesi_wr_blk, mesi_wr_data, shared, flush_req, flush_blk, snoop_done.
  - Reset mid-FLUSH drops flush_req immediately. No MESI write occurs.
- Command seen in IDLE at edge 0 gives LOOKUP in cycle 1. Then:
  - Miss: snoop_done in cycle 2.
  - Non-M hit: UPDATE in cycle 2, snoop_done in cycle 3.
  - M hit: FLUSH from cycle 2. If flush_done arrives in cycle 2+k, UPDATE is in cycle 3+k and snoop_done in 4+k.
- flush_done asserted outside FLUSH is ignored.
- Processor grant: cpu_lookup_gnt=1 the cycle after req is seen in IDLE with no snoop pending. It drops the cycle after req falls.
- A snoop command arriving while in CPU is served starting the cycle after gnt drops.
- Back-to-back snoops are separated by at least one IDLE cycle.

## Test plan
- bus_rd, access_blk_snoop=4'b0100, way2 state E -> LOOKUP, then UPDATE with mesi_wr_blk=2, mesi_wr_data=S, then snoop_done in cycle 3; shared=1 in cycles 2–3.
- bus_rdx, hit way1 state M, flush_done 3 cycles after flush_req -> flush_req/flush_blk=1 for 3 cycles, then mesi_wr_data=I, then snoop_done; shared stays 0.
- invalidate, hit way3 state M -> no flush_req; UPDATE writes I to way3; snoop_done in cycle 3.
- bus_rd, access_blk_snoop=0 -> no mesi_wr_en; shared=0; snoop_done in cycle 2.
- cpu_lookup_req held 5 cycles, bus_rd arrives in cycle 2 -> gnt held through release; snoop_sel rises 1 cycle after gnt falls; snoop_sel and gnt never overlap. Simultaneous req and command in IDLE -> snoop served first.
- rst asserted in FLUSH -> flush_req and all outputs 0 asynchronously; after release, state IDLE and a new bus_rd completes normally.

Source files
------------

// File: rtl/snoop_ctrl_lv1.sv
// L1 snoop-side sequencer: serialises one bus snoop at a time against processor
// lookups on the shared tag/MESI port, and drives flush, MESI update and bus shared.
module snoop_ctrl_lv1 #(
  parameter int ASSOC     = 4,
  parameter int ASSOC_WID = 2,
  parameter int MESI_WID  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_rd,
  input  logic                      bus_rdx,
  input  logic                      invalidate,
  input  logic [ASSOC-1:0]          access_blk_snoop,
  input  logic [ASSOC*MESI_WID-1:0] cache_snoop_mesi,
  input  logic                      cpu_lookup_req,
  output logic                      cpu_lookup_gnt,
  output logic                      snoop_sel,
  output logic                      mesi_wr_en,
  output logic [ASSOC_WID-1:0]      mesi_wr_blk,
  output logic [MESI_WID-1:0]       mesi_wr_data,
  output logic                      shared,
  output logic                      flush_req,
  output logic [ASSOC_WID-1:0]      flush_blk,
  input  logic                      flush_done,
  output logic                      snoop_done
);

  localparam logic [MESI_WID-1:0] MESI_I = MESI_WID'(0);
  localparam logic [MESI_WID-1:0] MESI_S = MESI_WID'(1);
  localparam logic [MESI_WID-1:0] MESI_M = MESI_WID'(3);

  typedef enum logic [2:0] {IDLE, CPU, LOOKUP, FLUSH, UPDATE, DONE} state_t;
  typedef enum logic [1:0] {CMD_RD, CMD_RDX, CMD_INV} cmd_t;

  state_t               state, state_nxt;
  cmd_t                 cmd, cmd_nxt;
  logic [ASSOC_WID-1:0] blk, blk_nxt;
  logic                 shared_nxt;
  logic [ASSOC_WID-1:0] hit_idx;
  logic [MESI_WID-1:0]  hit_mesi;

  // Lowest-index way wins if the hit vector is (illegally) multi-hot.
  always_comb begin
    hit_idx  = '0;
    hit_mesi = '0;
    for (int i = ASSOC - 1; i >= 0; i--) begin
      if (access_blk_snoop[i]) begin
        hit_idx  = ASSOC_WID'(i);
        hit_mesi = cache_snoop_mesi[i*MESI_WID +: MESI_WID];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd;
    blk_nxt    = blk;
    shared_nxt = shared;
    case (state)
      IDLE: begin
        if (bus_rdx) begin
          state_nxt = LOOKUP;
          cmd_nxt   = CMD_RDX;
        end else if (bus_rd) begin
          state_nxt = LOOKUP;
          cmd_nxt   = CMD_RD;
        end else if (invalidate) begin
          state_nxt = LOOKUP;
          cmd_nxt   = CMD_INV;
        end else if (cpu_lookup_req) begin
          state_nxt = CPU;
        end
      end
      CPU:    if (!cpu_lookup_req) state_nxt = IDLE;
      LOOKUP: begin
        blk_nxt = hit_idx;
        if (!(|access_blk_snoop)) begin
          state_nxt = DONE;
        end else begin
          if (cmd == CMD_RD) shared_nxt = 1'b1;
          // Invalidate drops the line without writing it back.
          if (hit_mesi == MESI_M && cmd != CMD_INV) state_nxt = FLUSH;
          else                                      state_nxt = UPDATE;
        end
      end
      FLUSH:  if (flush_done) state_nxt = UPDATE;
      UPDATE: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) shared_nxt = 1'b0;
  end

  // Outputs are decoded from the next state so every one comes straight off a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cmd            <= CMD_RD;
      blk            <= '0;
      cpu_lookup_gnt <= 1'b0;
      snoop_sel      <= 1'b0;
      mesi_wr_en     <= 1'b0;
      mesi_wr_blk    <= '0;
      mesi_wr_data   <= '0;
      shared         <= 1'b0;
      flush_req      <= 1'b0;
      flush_blk      <= '0;
      snoop_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cmd            <= cmd_nxt;
      blk            <= blk_nxt;
      cpu_lookup_gnt <= (state_nxt == CPU);
      snoop_sel      <= (state_nxt == LOOKUP) || (state_nxt == FLUSH) || (state_nxt == UPDATE);
      mesi_wr_en     <= (state_nxt == UPDATE);
      mesi_wr_blk    <= (state_nxt == UPDATE) ? blk_nxt : '0;
      mesi_wr_data   <= (state_nxt != UPDATE) ? '0 : (cmd_nxt == CMD_RD) ? MESI_S : MESI_I;
      shared         <= shared_nxt;
      flush_req      <= (state_nxt == FLUSH);
      flush_blk      <= (state_nxt == FLUSH) ? blk_nxt : '0;
      snoop_done     <= (state_nxt == DONE);
    end
  end

endmodule
